// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and encodings for the pipelined MIPS front end
package cpu_pkg;

    localparam int unsigned  WIDTH_DEF     = 32;
    localparam logic [31:0]  RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0]  EXC_VEC_DEF   = 32'h0000_4180;
    localparam int unsigned  STEP_DEF      = 4;

    // Redirect source, ordered lowest to highest priority; also used by the hazard unit.
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_JUMP   = 3'd1,
        SRC_BRANCH = 3'd2,
        SRC_ERET   = 3'd3,
        SRC_EXC    = 3'd4
    } redirect_src_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/redirect_arb.sv
// rtl/redirect_arb.sv - fixed-priority redirect selector: exc_req > eret > br_taken > jump
module redirect_arb
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VEC_DEF)
) (
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic             valid,
    output logic             is_exc,
    output logic [WIDTH-1:0] target
);

    redirect_src_t src;

    always_comb begin
        src    = SRC_NONE;
        target = '0;
        if (exc_req) begin
            src    = SRC_EXC;
            target = EXC_VEC;
        end else if (eret) begin
            src    = SRC_ERET;
            target = epc_in;
        end else if (br_taken) begin
            src    = SRC_BRANCH;
            target = br_target;
        end else if (jump) begin
            src    = SRC_JUMP;
            target = jump_target;
        end
    end

    assign valid  = (src != SRC_NONE);
    assign is_exc = (src == SRC_EXC);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with stall/back-pressure handling and latched redirects
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
    parameter int unsigned      STEP      = STEP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             fetch_valid,
    output logic             misalign,
    output logic             redirect_pending
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    pc_state_t        state, state_next;
    logic [WIDTH-1:0] pc_next;
    logic             pend_valid, pend_valid_next;
    logic             pend_exc, pend_exc_next;
    logic [WIDTH-1:0] pend_target, pend_target_next;

    logic             live_valid;
    logic             live_exc;
    logic [WIDTH-1:0] live_target;
    logic             advance;

    redirect_arb #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC)
    ) u_arb (
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc_in      (epc_in),
        .valid       (live_valid),
        .is_exc      (live_exc),
        .target      (live_target)
    );

    assign advance = (state == ST_RUN) && !stall && fetch_ready;

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_valid_next  = pend_valid;
        pend_exc_next    = pend_exc;
        pend_target_next = pend_target;

        if (state == ST_BOOT) begin
            state_next = ST_RUN;
        end

        if (advance) begin
            // A latched exception must not be lost to a younger live redirect.
            if (pend_valid && pend_exc) begin
                pc_next = EXC_VEC;
            end else if (live_valid) begin
                pc_next = live_target;
            end else if (pend_valid) begin
                pc_next = pend_target;
            end else begin
                pc_next = pc + STEP_W;
            end
            pend_valid_next  = 1'b0;
            pend_exc_next    = 1'b0;
            pend_target_next = '0;
        end else if (live_valid && (live_exc || !(pend_valid && pend_exc))) begin
            pend_valid_next  = 1'b1;
            pend_exc_next    = live_exc;
            pend_target_next = live_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_valid  <= pend_valid_next;
            pend_exc    <= pend_exc_next;
            pend_target <= pend_target_next;
        end
    end

    assign pc_plus_step     = pc + STEP_W;
    assign misalign         = (pc & ALIGN_MASK) != '0;
    assign redirect_pending = pend_valid;
    // A pending redirect means the PC currently presented is on the wrong path.
    assign fetch_valid      = (state == ST_RUN) && !misalign && !pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed scoreboard bench for pc_gen (32-bit and 8-bit instances)
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, reset8;
    logic        stall, fetch_ready, br_taken, jump, exc_req, eret;
    logic [31:0] br_target, jump_target, epc_in;

    logic [31:0] pc, pc_plus_step;
    logic        fetch_valid, misalign, redirect_pending;

    logic [7:0]  pc8, pc_plus_step8;
    logic        fetch_valid8, misalign8, redirect_pending8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pps;
        logic        fv;
        logic        rp;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_gen dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .exc_req          (exc_req),
        .eret             (eret),
        .epc_in           (epc_in),
        .pc               (pc),
        .pc_plus_step     (pc_plus_step),
        .fetch_valid      (fetch_valid),
        .misalign         (misalign),
        .redirect_pending (redirect_pending)
    );

    pc_gen #(
        .WIDTH     (8),
        .RESET_VEC (8'hF0),
        .EXC_VEC   (8'h80),
        .STEP      (4)
    ) dut8 (
        .clk              (clk),
        .reset            (reset8),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .br_taken         (br_taken),
        .br_target        (br_target[7:0]),
        .jump             (jump),
        .jump_target      (jump_target[7:0]),
        .exc_req          (exc_req),
        .eret             (eret),
        .epc_in           (epc_in[7:0]),
        .pc               (pc8),
        .pc_plus_step     (pc_plus_step8),
        .fetch_valid      (fetch_valid8),
        .misalign         (misalign8),
        .redirect_pending (redirect_pending8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_redirects();
        br_taken = 1'b0;
        jump     = 1'b0;
        exc_req  = 1'b0;
        eret     = 1'b0;
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic step(input string tag, input bit on8, input logic [31:0] epc,
                        input logic efv, input logic erp, input logic emis);
        exp_t e;
        e.pc  = epc;
        e.pps = on8 ? {24'h0, epc[7:0] + 8'd4} : epc + 32'd4;
        e.fv  = efv;
        e.rp  = erp;
        e.mis = emis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (on8) begin
            chk({tag, ".pc"},  {24'h0, pc8},            e.pc);
            chk({tag, ".pps"}, {24'h0, pc_plus_step8},  e.pps);
            chk({tag, ".fv"},  {31'h0, fetch_valid8},   {31'h0, e.fv});
            chk({tag, ".rp"},  {31'h0, redirect_pending8}, {31'h0, e.rp});
            chk({tag, ".mis"}, {31'h0, misalign8},      {31'h0, e.mis});
        end else begin
            chk({tag, ".pc"},  pc,                      e.pc);
            chk({tag, ".pps"}, pc_plus_step,            e.pps);
            chk({tag, ".fv"},  {31'h0, fetch_valid},    {31'h0, e.fv});
            chk({tag, ".rp"},  {31'h0, redirect_pending}, {31'h0, e.rp});
            chk({tag, ".mis"}, {31'h0, misalign},       {31'h0, e.mis});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; reset8 = 1'b1;
        stall = 1'b0; fetch_ready = 1'b1;
        clear_redirects();
        br_target = '0; jump_target = '0; epc_in = '0;
        @(posedge clk); #1;

        step("reset",  0, 32'h3000, 0, 0, 0);
        reset = 1'b0;
        step("run0",   0, 32'h3000, 1, 0, 0);
        step("seq1",   0, 32'h3004, 1, 0, 0);
        step("seq2",   0, 32'h3008, 1, 0, 0);

        br_taken = 1'b1; br_target = 32'h3100;
        jump = 1'b1; jump_target = 32'h3200;
        step("br_over_jump", 0, 32'h3100, 1, 0, 0);
        clear_redirects();

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3040;
        step("stall1", 0, 32'h3100, 0, 1, 0);
        clear_redirects();
        step("stall2", 0, 32'h3100, 0, 1, 0);
        step("stall3", 0, 32'h3100, 0, 1, 0);
        stall = 1'b0;
        step("stall_release", 0, 32'h3040, 1, 0, 0);

        fetch_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3040;
        step("bp_branch", 0, 32'h3040, 0, 1, 0);
        clear_redirects(); exc_req = 1'b1;
        step("bp_exc", 0, 32'h3040, 0, 1, 0);
        clear_redirects(); jump = 1'b1; jump_target = 32'h3300;
        step("bp_jump_blocked", 0, 32'h3040, 0, 1, 0);
        clear_redirects(); fetch_ready = 1'b1;
        step("exc_applied", 0, 32'h4180, 1, 0, 0);

        eret = 1'b1; epc_in = 32'h3002;
        step("eret_misalign", 0, 32'h3002, 0, 0, 1);
        clear_redirects(); exc_req = 1'b1;
        step("misalign_exc", 0, 32'h4180, 1, 0, 0);

        clear_redirects(); fetch_ready = 1'b0; exc_req = 1'b1;
        step("pend_exc", 0, 32'h4180, 0, 1, 0);
        clear_redirects(); fetch_ready = 1'b1; br_taken = 1'b1; br_target = 32'h3500;
        step("pend_exc_beats_live", 0, 32'h4180, 1, 0, 0);

        clear_redirects(); fetch_ready = 1'b0; jump = 1'b1; jump_target = 32'h3600;
        step("pend_jump", 0, 32'h4180, 0, 1, 0);
        clear_redirects(); fetch_ready = 1'b1; br_taken = 1'b1; br_target = 32'h3700;
        step("live_beats_pend", 0, 32'h3700, 1, 0, 0);
        clear_redirects();
        step("seq_after", 0, 32'h3704, 1, 0, 0);

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3800;
        step("pend_before_reset", 0, 32'h3704, 0, 1, 0);
        clear_redirects(); reset = 1'b1;
        step("mid_reset", 0, 32'h3000, 0, 0, 0);
        reset = 1'b0; stall = 1'b0; jump = 1'b1; jump_target = 32'h3900;
        step("boot_latch", 0, 32'h3000, 0, 1, 0);
        clear_redirects();
        step("boot_apply", 0, 32'h3900, 1, 0, 0);

        reset = 1'b1;
        step("w8_reset", 1, 32'hF0, 0, 0, 0);
        reset8 = 1'b0;
        step("w8_run",   1, 32'hF0, 1, 0, 0);
        step("w8_f4",    1, 32'hF4, 1, 0, 0);
        step("w8_f8",    1, 32'hF8, 1, 0, 0);
        step("w8_fc",    1, 32'hFC, 1, 0, 0);
        step("w8_wrap",  1, 32'h00, 1, 0, 0);
        step("w8_04",    1, 32'h04, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
